// File: rtl/core_pkg.sv
// Shared writeback-stage types: result-select encoding, load funct3 codes and
// the writeback occupancy states.
package core_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } res_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        HOLD    = 2'b01,
        WAIT_LD = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extractor: picks byte/half/word at the address offset,
// extends it, and flags misaligned or illegal load types.
module load_align
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            off_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
        data_o   = '0;
        err_o    = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                err_o  = off_i[0];
            end
            F3_LHU: begin
                data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                err_o  = off_i[0];
            end
            F3_LW: begin
                data_o = rdata_i;
                err_o  = (off_i != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: holds one MEM/WB instruction, waits for load data,
// drives the register-file write port, forwarding tap and instret counter.
module wb_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_rd,
    input  logic                     in_reg_write,
    input  logic [1:0]               in_res_sel,
    input  logic [DATA_WIDTH-1:0]    in_alu_result,
    input  logic [DATA_WIDTH-1:0]    in_pc_plus4,
    input  logic [2:0]               in_funct3,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [ADDRESS_WIDTH-1:0] WriteAddr,
    output logic [DATA_WIDTH-1:0]    WriteData,
    output logic                     WriteEnable,
    output logic                     fwd_valid,
    output logic [ADDRESS_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]    fwd_data,
    output logic                     load_err,
    output logic [CNT_WIDTH-1:0]     instret
);

    wb_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic                     reg_write_q;
    logic [1:0]               res_sel_q;
    logic [DATA_WIDTH-1:0]    alu_q, pc4_q;
    logic [2:0]               funct3_q;
    logic [CNT_WIDTH-1:0]     instret_q;

    logic                  retire, accept, ld_err, err_eff;
    logic [DATA_WIDTH-1:0] ld_data, result;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .funct3_i (funct3_q),
        .off_i    (alu_q[1:0]),
        .rdata_i  (mem_rdata),
        .data_o   (ld_data),
        .err_o    (ld_err)
    );

    always_comb begin
        retire   = (state_q == HOLD) || ((state_q == WAIT_LD) && mem_rvalid);
        in_ready = !rst && ((state_q == EMPTY) || retire);
        accept   = in_valid && in_ready;
        state_d  = state_q;
        if (accept)
            state_d = (in_res_sel == RES_LOAD) ? WAIT_LD : HOLD;
        else if (retire)
            state_d = EMPTY;
    end

    // Reserved select 2'b11 retires with a zero result and never writes.
    always_comb begin
        case (res_sel_q)
            RES_ALU:  result = alu_q;
            RES_LOAD: result = ld_data;
            RES_PC4:  result = pc4_q;
            default:  result = '0;
        endcase
        err_eff     = (res_sel_q == RES_LOAD) && ld_err;
        WriteEnable = retire && reg_write_q && (rd_q != '0) && !err_eff
                      && (res_sel_q != 2'b11);
        WriteAddr   = WriteEnable ? rd_q : '0;
        WriteData   = WriteEnable ? result : '0;
        load_err    = retire && err_eff;
        fwd_valid   = WriteEnable;
        fwd_rd      = WriteAddr;
        fwd_data    = WriteData;
        instret     = instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            res_sel_q   <= 2'b00;
            alu_q       <= '0;
            pc4_q       <= '0;
            funct3_q    <= '0;
            instret_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q        <= in_rd;
                reg_write_q <= in_reg_write;
                res_sel_q   <= in_res_sel;
                alu_q       <= in_alu_result;
                pc4_q       <= in_pc_plus4;
                funct3_q    <= in_funct3;
            end
            if (retire)
                instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// against a behavioural single-slot writeback model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_res_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        WriteEnable;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_err;
    logic [63:0] instret;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_instret;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
    } instr_t;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_res_sel(in_res_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_funct3(in_funct3), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_err(load_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_t t);
        in_valid      = 1'b1;
        in_rd         = t.rd;
        in_reg_write  = t.rw;
        in_res_sel    = t.sel;
        in_alu_result = t.alu;
        in_pc_plus4   = t.pc4;
        in_funct3     = t.f3;
    endtask

    function automatic instr_t mk(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                  input logic [31:0] alu, input logic [31:0] pc4,
                                  input logic [2:0] f3);
        instr_t t;
        t.rd = rd; t.rw = rw; t.sel = sel; t.alu = alu; t.pc4 = pc4; t.f3 = f3;
        return t;
    endfunction

    // Reference: what the register file should see when instruction h retires.
    task automatic model(input instr_t h, input logic [31:0] rdata,
                         output logic we, output logic [31:0] data, output logic err);
        int          off;
        logic [31:0] sh;
        off  = int'(h.alu[1:0]);
        sh   = rdata >> (8 * off);
        err  = 1'b0;
        data = 32'h0;
        case (h.sel)
            2'd0: data = h.alu;
            2'd2: data = h.pc4;
            2'd1: begin
                case (h.f3)
                    3'd0: data = {{24{sh[7]}}, sh[7:0]};
                    3'd4: data = sh & 32'hFF;
                    3'd1: begin data = {{16{sh[15]}}, sh[15:0]}; err = (off % 2) != 0; end
                    3'd5: begin data = sh & 32'hFFFF;            err = (off % 2) != 0; end
                    3'd2: begin data = rdata;                   err = off != 0; end
                    default: err = 1'b1;
                endcase
            end
            default: data = 32'h0;
        endcase
        we = h.rw && (h.rd != 5'd0) && !err && (h.sel != 2'd3);
        if (!we) data = 32'h0;
    endtask

    // Issue a load, return it with rdata one cycle later; samples the retire cycle.
    task automatic run_load(input instr_t t, input logic [31:0] rdata,
                            output logic we, output logic [31:0] data, output logic err);
        drive(t);
        tick();
        in_valid   = 1'b0;
        mem_rdata  = rdata;
        mem_rvalid = 1'b1;
        #1;
        we   = WriteEnable;
        data = WriteData;
        err  = load_err;
        tick();
        mem_rvalid  = 1'b0;
        exp_instret = exp_instret + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_res_sel = '0;
        in_alu_result = '0; in_pc_plus4 = '0; in_funct3 = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        exp_instret = 64'd0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++; if ({WriteEnable, WriteAddr, WriteData, load_err, fwd_valid} !== '0) begin
            errors++; $display("FAIL reset_outputs: we=%b addr=%h data=%h err=%b", WriteEnable, WriteAddr, WriteData, load_err);
        end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_alu();
        drive(mk(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'd0));
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (WriteEnable !== 1'b1 || WriteAddr !== 5'd5 || WriteData !== 32'h1234_5678) begin
            errors++; $display("FAIL alu_write: got we=%b addr=%0d data=%h want 1/5/12345678", WriteEnable, WriteAddr, WriteData);
        end
        checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234_5678) begin
            errors++; $display("FAIL alu_fwd: got v=%b rd=%0d data=%h", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret || WriteEnable !== 1'b0) begin
            errors++; $display("FAIL alu_instret: got %0d we=%b want %0d we=0", instret, WriteEnable, exp_instret);
        end
    endtask

    task automatic test_lb_delay();
        drive(mk(5'd9, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'd0));
        tick();
        in_valid  = 1'b0;
        mem_rdata = 32'h80FF_FF00;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || WriteEnable !== 1'b0) begin
                errors++; $display("FAIL lb_wait%0d: got ready=%b we=%b want 0/0", i, in_ready, WriteEnable);
            end
            tick();
        end
        mem_rvalid = 1'b1;
        #1;
        checks++; if (WriteEnable !== 1'b1 || WriteAddr !== 5'd9 || WriteData !== 32'hFFFF_FF80 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lb_data: got we=%b addr=%0d data=%h ready=%b want 1/9/ffffff80/1", WriteEnable, WriteAddr, WriteData, in_ready);
        end
        tick();
        mem_rvalid  = 1'b0;
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lb_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_half();
        logic we, err;
        logic [31:0] d;
        run_load(mk(5'd10, 1'b1, 2'b01, 32'h0000_0002, 32'h0, 3'd5), 32'hBEEF_0000, we, d, err);
        checks++; if (we !== 1'b1 || d !== 32'h0000_BEEF || err !== 1'b0) begin
            errors++; $display("FAIL lhu: got we=%b data=%h err=%b want 1/0000beef/0", we, d, err);
        end
        run_load(mk(5'd11, 1'b1, 2'b01, 32'h0000_0002, 32'h0, 3'd1), 32'hBEEF_0000, we, d, err);
        checks++; if (we !== 1'b1 || d !== 32'hFFFF_BEEF || err !== 1'b0) begin
            errors++; $display("FAIL lh: got we=%b data=%h err=%b want 1/ffffbeef/0", we, d, err);
        end
    endtask

    task automatic test_misaligned();
        logic we, err;
        logic [31:0] d;
        run_load(mk(5'd7, 1'b1, 2'b01, 32'h0000_0001, 32'h0, 3'd2), 32'hCAFE_F00D, we, d, err);
        checks++; if (err !== 1'b1 || we !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL lw_misaligned: got err=%b we=%b data=%h want 1/0/0", err, we, d);
        end
        checks++; if (load_err !== 1'b0 || instret !== exp_instret) begin
            errors++; $display("FAIL lw_misaligned_after: got err=%b instret=%0d want 0/%0d", load_err, instret, exp_instret);
        end
    endtask

    task automatic test_x0();
        drive(mk(5'd0, 1'b1, 2'b00, 32'h0000_DEAD, 32'h0, 3'd0));
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (WriteEnable !== 1'b0 || load_err !== 1'b0 || WriteData !== 32'h0) begin
            errors++; $display("FAIL x0_write: got we=%b err=%b data=%h want 0/0/0", WriteEnable, load_err, WriteData);
        end
        tick();
        exp_instret = exp_instret + 1;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL x0_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] base;
        base = exp_instret;
        drive(mk(5'd1, 1'b1, 2'b10, 32'h0, 32'h4, 3'd0));
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) drive(mk(5'(i + 1), 1'b1, 2'b10, 32'h0, 32'(4 * (i + 1)), 3'd0));
            else in_valid = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b1 || WriteEnable !== 1'b1 || WriteAddr !== 5'(i) || WriteData !== 32'(4 * i)) begin
                errors++; $display("FAIL b2b_%0d: got ready=%b we=%b addr=%0d data=%h want 1/1/%0d/%h",
                                   i, in_ready, WriteEnable, WriteAddr, WriteData, i, 4 * i);
            end
            tick();
            exp_instret = exp_instret + 1;
        end
        checks++; if (instret !== base + 64'd4) begin errors++; $display("FAIL b2b_instret: got %0d want %0d", instret, base + 4); end
    endtask

    task automatic test_random();
        instr_t      held, nxt;
        logic        full;
        logic        ld_held, ret, exp_ready, we, err;
        logic [31:0] d;
        full = 1'b0;
        held = mk('0, 1'b0, '0, '0, '0, '0);
        for (int n = 0; n < 400; n++) begin
            nxt = mk(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     $urandom, $urandom, 3'($urandom_range(0, 7)));
            drive(nxt);
            in_valid   = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            #1;
            ld_held   = full && (held.sel == 2'b01);
            ret       = full && (!ld_held || mem_rvalid);
            exp_ready = !full || ret;
            we = 1'b0; d = 32'h0; err = 1'b0;
            if (ret) model(held, mem_rdata, we, d, err);
            checks++; if (in_ready !== exp_ready || WriteEnable !== we || WriteData !== d || load_err !== err
                          || WriteAddr !== (we ? held.rd : 5'd0) || instret !== exp_instret) begin
                errors++; $display("FAIL rand_%0d: got rdy=%b we=%b a=%0d d=%h err=%b ir=%0d want rdy=%b we=%b a=%0d d=%h err=%b ir=%0d",
                                   n, in_ready, WriteEnable, WriteAddr, WriteData, load_err, instret,
                                   exp_ready, we, we ? held.rd : 5'd0, d, err, exp_instret);
            end
            if (ret) exp_instret = exp_instret + 1;
            if (in_valid && exp_ready) begin held = nxt; full = 1'b1; end
            else if (ret) full = 1'b0;
            tick();
        end
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        tick(); tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_wait_ld();
        drive(mk(5'd3, 1'b1, 2'b01, 32'h0, 32'h0, 3'd2));
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_waiting: got ready=%b want 0", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || WriteEnable !== 1'b0 || instret !== 64'd0) begin
            errors++; $display("FAIL rst_ld_inreset: got ready=%b we=%b instret=%0d want 0/0/0", in_ready, WriteEnable, instret);
        end
        tick(); tick();
        rst         = 1'b0;
        exp_instret = 64'd0;
        mem_rdata   = 32'h1111_2222;
        mem_rvalid  = 1'b1;
        #1;
        checks++; if (WriteEnable !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ld_stale: got we=%b ready=%b want 0/1", WriteEnable, in_ready);
        end
        tick();
        mem_rvalid = 1'b0;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL rst_ld_instret: got %0d want 0", instret); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_delay();
        test_half();
        test_misaligned();
        test_x0();
        test_back_to_back();
        test_random();
        test_reset_wait_ld();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline.
- Holds one MEM/WB instruction, waits for load response data where needed, and aligns and sign/zero-extends load data.
- Selects the final result and drives the register-file write port (WriteAddr/WriteData/WriteEnable).
- Also exports a forwarding tap and a 64-bit retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath/register width
- ADDRESS_WIDTH, 5, register index width
- CNT_WIDTH, 64, instret counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rd  in  ADDRESS_WIDTH  destination register
- in_reg_write  in  1  instruction writes rd
- in_res_sel  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved
- in_alu_result  in  DATA_WIDTH  ALU result; bits[1:0] are the load byte offset
- in_pc_plus4  in  DATA_WIDTH  link value
- in_funct3  in  3  load type
- mem_rvalid  in  1  load response data valid
- mem_rdata  in  DATA_WIDTH  raw aligned load word
- WriteAddr  out  ADDRESS_WIDTH  register-file write index
- WriteData  out  DATA_WIDTH  register-file write data
- WriteEnable  out  1  register-file write strobe
- fwd_valid  out  1  forwarding tap valid; equals WriteEnable
- fwd_rd  out  ADDRESS_WIDTH  equals WriteAddr
- fwd_data  out  DATA_WIDTH  equals WriteData
- load_err  out  1  one-cycle pulse on an illegal or misaligned load
- instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Under reset: stage empty, all outputs 0, instret 0, in_ready 0 while rst is high.
- States:
  - EMPTY: no held instruction.
  - HOLD: non-load instruction held.
  - WAIT_LD: load held, data not yet returned.
- Accept: on a clk edge with in_valid && in_ready, all in_* fields are registered. Next state is WAIT_LD if in_res_sel==01, otherwise HOLD.
- in_ready (combinational) = EMPTY || retire.
- retire (combinational) = HOLD || (WAIT_LD && mem_rvalid).
- On retire without a new accept, the next state is EMPTY. Back-to-back accept on the retire cycle is legal and yields full throughput of 1 instr/cycle.
- Latency:
  - Non-load accepted at edge N: WriteEnable high during cycle N+1, register written at edge N+1.
  - Load: write occurs in the first cycle after accept in which mem_rvalid=1. mem_rvalid while EMPTY or HOLD is ignored.
- WriteEnable = retire && reg_write && rd!=0 && !err. WriteAddr/WriteData are valid when WriteEnable=1, else 0.
- Result mux: 00 alu_result, 10 pc_plus4, 11 gives 0 with no write.
- Load extraction (off = alu_result[1:0]):
  - LB (000): byte at off, sign-extended.
  - LBU (100): byte at off, zero-extended.
  - LH (001): half at off[1], sign-extended.
  - LHU (101): half at off[1], zero-extended.
  - LW (010): full word.
- Load errors:
  - Misaligned: half with off[0]=1, or word with off!=0.
  - Illegal: funct3 011/110/111.
  - In both cases: load_err pulses in the retire cycle, no write, instruction still counts as retired.
- instret increments by 1 on every retire and wraps modulo 2^CNT_WIDTH.
- Reset mid-WAIT_LD drops the load. A later stale mem_rvalid is ignored because the stage is EMPTY.

Decomposition:
- Shared package core_pkg:
  - res_sel_e enum (RES_ALU, RES_LOAD, RES_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_e (EMPTY, HOLD, WAIT_LD).
- One sub-module: load_align. A purely combinational funct3/offset/rdata-to-data+err extractor, instantiated once.

Test Plan:
- ALU op: rd=5, alu_result=0x1234_5678, res_sel=00, accepted edge 0 -> WriteEnable=1, WriteAddr=5, WriteData=0x12345678 in cycle 1; instret=1 after edge 1.
- LB with delayed data: funct3=000, off=3, mem_rdata=0x80FF_FF00, mem_rvalid low 3 cycles then high -> in_ready=0 during wait; WriteData=0xFFFF_FF80 in the rvalid cycle.
- LHU off=2 with rdata 0xBEEF_0000 -> 0x0000_BEEF. LH with same inputs -> 0xFFFF_BEEF.
- Misaligned LW off=1, rd=7 -> load_err pulse, WriteEnable=0, instret increments.
- Write to x0: rd=0, alu_result=0xDEAD -> WriteEnable=0, no error.
- Back-to-back streaming: in_valid=1 for 4 JAL ops (res_sel=10, pc_plus4 0x4,0x8,0xC,0x10) -> in_ready stays 1; writes appear on 4 consecutive cycles; instret=4.
- Reset in WAIT_LD, then mem_rvalid=1 after release -> no write, instret=0.
